// File: rtl/dma_pkg.sv
// Shared definitions for the word-copy DMA engine: register map, CTRL bit
// positions, controller state encoding and bus access-size codes.
package dma_pkg;

  localparam logic [3:0] REG_SRC  = 4'h0;
  localparam logic [3:0] REG_DST  = 4'h4;
  localparam logic [3:0] REG_LEN  = 4'h8;
  localparam logic [3:0] REG_CTRL = 4'hC;

  // START (write) and BUSY (read) share bit 0 of CTRL
  localparam int CTRL_START  = 0;
  localparam int CTRL_BUSY   = 0;
  localparam int CTRL_IRQ_EN = 1;
  localparam int CTRL_DONE   = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_FIN  = 2'd3
  } state_t;

  localparam logic [1:0] HB_BYTE = 2'b00;
  localparam logic [1:0] HB_HALF = 2'b01;
  localparam logic [1:0] HB_WORD = 2'b10;

endpackage

// File: rtl/dma_engine_if.sv
// Bus bundle for the DMA engine: register responder port, memory initiator
// port and the interrupt line. The slave modport is the engine's own view.
interface dma_engine_if;

  logic        i_S_CE;
  logic        i_S_REQ;
  logic        i_S_WE;
  logic [3:0]  i_S_ADDR;
  logic [31:0] i_S_WDATA;
  logic [31:0] o_S_RDATA;
  logic        o_S_GNT;

  logic        o_M_REQ;
  logic        o_M_RE;
  logic        o_M_WE;
  logic [31:0] o_M_ADDR;
  logic [31:0] o_M_WDATA;
  logic [1:0]  o_M_HB;
  logic        i_M_GNT;
  logic [31:0] i_M_RDATA;

  logic        o_IRQ;

  modport slave (
    input  i_S_CE, i_S_REQ, i_S_WE, i_S_ADDR, i_S_WDATA,
    output o_S_RDATA, o_S_GNT,
    output o_M_REQ, o_M_RE, o_M_WE, o_M_ADDR, o_M_WDATA, o_M_HB,
    input  i_M_GNT, i_M_RDATA,
    output o_IRQ
  );

  modport master (
    output i_S_CE, i_S_REQ, i_S_WE, i_S_ADDR, i_S_WDATA,
    input  o_S_RDATA, o_S_GNT,
    input  o_M_REQ, o_M_RE, o_M_WE, o_M_ADDR, o_M_WDATA, o_M_HB,
    output i_M_GNT, i_M_RDATA,
    input  o_IRQ
  );

endinterface

// File: rtl/dma_engine.sv
// Single-channel word-copy DMA: programmed through four registers, moves LEN
// words from SRC to DST one read/write pair at a time, flags DONE/IRQ at the end.
module dma_engine #(
  parameter int LEN_W = 16
) (
  input logic         i_CLK,
  input logic         i_RST,
  dma_engine_if.slave bus
);
  import dma_pkg::*;

  state_t state, state_nxt;

  logic [31:0]      src_reg, dst_reg;
  logic [LEN_W-1:0] len_reg;
  logic             irq_en, done;

  logic [31:0]      src_ptr, dst_ptr, data_buf;
  logic [LEN_W-1:0] count;

  logic             s_gnt;
  logic [31:0]      s_rdata, rd_mux;
  logic             req_hold;

  logic busy, s_acc, s_wr, ctrl_wr, start_cmd, m_req, m_acc, last_word;

  assign busy      = (state == ST_RD) || (state == ST_WR);
  // A request presented while the grant is still high is held off a cycle
  assign s_acc     = bus.i_S_CE & bus.i_S_REQ & ~s_gnt;
  assign s_wr      = s_acc & bus.i_S_WE;
  assign ctrl_wr   = s_wr && (bus.i_S_ADDR == REG_CTRL);
  assign start_cmd = ctrl_wr & bus.i_S_WDATA[CTRL_START];
  assign m_acc     = bus.i_M_GNT & m_req;
  assign last_word = (count == {{(LEN_W-1){1'b0}}, 1'b1});

  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start_cmd) state_nxt = (len_reg != '0) ? ST_RD : ST_FIN;
      ST_RD:   if (m_acc)     state_nxt = ST_WR;
      ST_WR:   if (m_acc)     state_nxt = last_word ? ST_FIN : ST_RD;
      ST_FIN:                 state_nxt = ST_IDLE;
      default:                state_nxt = ST_IDLE;
    endcase
  end

  // req_hold forces the mandatory idle cycle after each initiator grant
  always_comb begin
    m_req         = 1'b0;
    bus.o_M_RE    = 1'b0;
    bus.o_M_WE    = 1'b0;
    bus.o_M_ADDR  = '0;
    bus.o_M_WDATA = '0;
    case (state)
      ST_RD: begin
        m_req        = ~req_hold;
        bus.o_M_RE   = ~req_hold;
        bus.o_M_ADDR = src_ptr;
      end
      ST_WR: begin
        m_req         = ~req_hold;
        bus.o_M_WE    = ~req_hold;
        bus.o_M_ADDR  = dst_ptr;
        bus.o_M_WDATA = data_buf;
      end
      default: ;
    endcase
  end

  always_comb begin
    rd_mux = '0;
    case (bus.i_S_ADDR)
      REG_SRC:  rd_mux = src_reg;
      REG_DST:  rd_mux = dst_reg;
      REG_LEN:  rd_mux = 32'(len_reg);
      REG_CTRL: begin
        rd_mux[CTRL_BUSY]   = busy;
        rd_mux[CTRL_IRQ_EN] = irq_en;
        rd_mux[CTRL_DONE]   = done;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      s_gnt   <= 1'b0;
      s_rdata <= '0;
    end else begin
      s_gnt <= s_acc;
      if (s_acc) s_rdata <= rd_mux;
    end
  end

  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      src_reg  <= '0;
      dst_reg  <= '0;
      len_reg  <= '0;
      irq_en   <= 1'b0;
      done     <= 1'b0;
      src_ptr  <= '0;
      dst_ptr  <= '0;
      count    <= '0;
      data_buf <= '0;
      req_hold <= 1'b0;
    end else begin
      req_hold <= m_acc;
      if (s_wr && !busy) begin
        case (bus.i_S_ADDR)
          REG_SRC: src_reg <= bus.i_S_WDATA;
          REG_DST: dst_reg <= bus.i_S_WDATA;
          REG_LEN: len_reg <= bus.i_S_WDATA[LEN_W-1:0];
          default: ;
        endcase
      end
      if (ctrl_wr) irq_en <= bus.i_S_WDATA[CTRL_IRQ_EN];
      // Completion wins over a simultaneous write-1-to-clear
      if (state == ST_FIN)                             done <= 1'b1;
      else if (ctrl_wr && bus.i_S_WDATA[CTRL_DONE])    done <= 1'b0;
      if (state == ST_IDLE && start_cmd && len_reg != '0) begin
        src_ptr <= src_reg;
        dst_ptr <= dst_reg;
        count   <= len_reg;
      end
      if (state == ST_RD && m_acc) data_buf <= bus.i_M_RDATA;
      if (state == ST_WR && m_acc) begin
        src_ptr <= src_ptr + 32'd4;
        dst_ptr <= dst_ptr + 32'd4;
        count   <= count - 1'b1;
      end
    end
  end

  assign bus.o_S_GNT   = s_gnt;
  assign bus.o_S_RDATA = s_rdata;
  assign bus.o_M_REQ   = m_req;
  assign bus.o_M_HB    = HB_WORD;
  assign bus.o_IRQ     = done & irq_en;

endmodule

// File: tb/tb_dma_engine.sv
// Randomized bench for dma_engine: a memory responder with variable grant
// latency plus a queue of expected bus operations derived from SRC/DST/LEN.
module tb_dma_engine;
  import dma_pkg::*;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
  } bus_op_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  dma_engine_if bus_if();

  dma_engine #(.LEN_W(16)) dut (
    .i_CLK (clk),
    .i_RST (rst),
    .bus   (bus_if)
  );

  always #5 clk = ~clk;

  int n_compared   = 0;
  int n_mismatched = 0;

  bus_op_t     exp_q[$];
  logic [31:0] rd_log[$];
  int          wr_count;
  logic [31:0] last_wr_addr;

  int      gnt_delay_max = 0;
  bit      fixed_delay   = 1'b1;
  bit      stray_en      = 1'b0;
  int      wait_cnt      = 0;
  int      delay_target  = 0;
  bit      gnt_prev      = 1'b0;
  bit      granted;
  bus_op_t head;

  logic [31:0] m_src, m_dst;
  logic [15:0] m_len;
  bit          m_irq_en, m_done;
  logic        irq_after_gnt;

  // Memory contents are a fixed function of address, so expected copies need no storage
  function automatic logic [31:0] mem_val(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  function automatic logic [31:0] ctrl_exp(input bit busy);
    return {29'd0, m_done, m_irq_en, busy};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] addr, input logic [31:0] data);
    bus_if.i_S_CE    = 1'b1;
    bus_if.i_S_REQ   = 1'b1;
    bus_if.i_S_WE    = 1'b1;
    bus_if.i_S_ADDR  = addr;
    bus_if.i_S_WDATA = data;
    @(negedge clk);
    checkOutput("s_gnt_write", 32'(bus_if.o_S_GNT), 32'd1);
    irq_after_gnt   = bus_if.o_IRQ;
    bus_if.i_S_CE   = 1'b0;
    bus_if.i_S_REQ  = 1'b0;
    bus_if.i_S_WE   = 1'b0;
    @(negedge clk);
    checkOutput("s_gnt_low_after", 32'(bus_if.o_S_GNT), 32'd0);
  endtask

  task automatic busRead(input logic [3:0] addr, output logic [31:0] data);
    bus_if.i_S_CE   = 1'b1;
    bus_if.i_S_REQ  = 1'b1;
    bus_if.i_S_WE   = 1'b0;
    bus_if.i_S_ADDR = addr;
    @(negedge clk);
    checkOutput("s_gnt_read", 32'(bus_if.o_S_GNT), 32'd1);
    data           = bus_if.o_S_RDATA;
    bus_if.i_S_CE  = 1'b0;
    bus_if.i_S_REQ = 1'b0;
    @(negedge clk);
  endtask

  task automatic setBusMode(input int max_delay, input bit fixed, input bit stray);
    gnt_delay_max = max_delay;
    fixed_delay   = fixed;
    stray_en      = stray;
    delay_target  = fixed ? max_delay : int'($urandom_range(0, max_delay));
  endtask

  task automatic startTransfer(input logic [31:0] src, input logic [31:0] dst,
                               input int len, input bit irq);
    applyStimulus(REG_SRC, src);
    applyStimulus(REG_DST, dst);
    applyStimulus(REG_LEN, 32'(len));
    m_src = src;
    m_dst = dst;
    m_len = 16'(len);
    rd_log.delete();
    wr_count = 0;
    for (int k = 0; k < len; k++) begin
      exp_q.push_back('{1'b0, src + 32'(4 * k), 32'd0});
      exp_q.push_back('{1'b1, dst + 32'(4 * k), mem_val(src + 32'(4 * k))});
    end
    m_irq_en = irq;
    applyStimulus(REG_CTRL, {29'd0, 1'b0, irq, 1'b1});
  endtask

  task automatic checkRegs(input bit busy);
    logic [31:0] r;
    busRead(REG_SRC, r);  checkOutput("reg_src", r, m_src);
    busRead(REG_DST, r);  checkOutput("reg_dst", r, m_dst);
    busRead(REG_LEN, r);  checkOutput("reg_len", r, 32'(m_len));
    busRead(REG_CTRL, r); checkOutput("reg_ctrl", r, ctrl_exp(busy));
  endtask

  task automatic finishTransfer(input int max_polls);
    logic [31:0] r;
    bit seen = 1'b0;
    for (int i = 0; i < max_polls && !seen; i++) begin
      busRead(REG_CTRL, r);
      if (r[CTRL_DONE]) seen = 1'b1;
    end
    checkOutput("done_within_bound", 32'(seen), 32'd1);
    checkOutput("queue_drained", 32'(exp_q.size()), 32'd0);
    m_done = 1'b1;
    checkRegs(1'b0);
    checkOutput("irq_level", 32'(bus_if.o_IRQ), 32'(m_irq_en));
    applyStimulus(REG_CTRL, {29'd0, 1'b1, m_irq_en, 1'b0});
    m_done = 1'b0;
    checkOutput("irq_cleared", 32'(bus_if.o_IRQ), 32'd0);
  endtask

  // Memory responder and per-cycle check of every initiator request
  always @(negedge clk) begin
    if (rst) begin
      bus_if.i_M_GNT   = 1'b0;
      bus_if.i_M_RDATA = '0;
      wait_cnt         = 0;
      gnt_prev         = 1'b0;
    end else begin
      granted = 1'b0;
      checkOutput("m_hb", 32'(bus_if.o_M_HB), 32'd2);
      if (gnt_prev) checkOutput("m_req_gap", 32'(bus_if.o_M_REQ), 32'd0);
      if (bus_if.o_M_REQ) begin
        checkOutput("m_req_expected", 32'(exp_q.size() != 0), 32'd1);
        bus_if.i_M_GNT = 1'b0;
        if (exp_q.size() != 0) begin
          head = exp_q[0];
          checkOutput("m_addr", bus_if.o_M_ADDR, head.addr);
          checkOutput("m_strobes", {30'd0, bus_if.o_M_WE, bus_if.o_M_RE},
                      {30'd0, head.we, ~head.we});
          if (head.we) checkOutput("m_wdata", bus_if.o_M_WDATA, head.data);
          if (wait_cnt >= delay_target) begin
            bus_if.i_M_GNT   = 1'b1;
            bus_if.i_M_RDATA = head.we ? $urandom : mem_val(head.addr);
            if (head.we) begin
              wr_count++;
              last_wr_addr = bus_if.o_M_ADDR;
            end else begin
              rd_log.push_back(bus_if.o_M_ADDR);
            end
            void'(exp_q.pop_front());
            wait_cnt     = 0;
            delay_target = fixed_delay ? gnt_delay_max : int'($urandom_range(0, gnt_delay_max));
            granted      = 1'b1;
          end else begin
            wait_cnt++;
          end
        end
      end else begin
        bus_if.i_M_GNT   = stray_en && ($urandom_range(0, 3) == 0);
        bus_if.i_M_RDATA = $urandom;
      end
      gnt_prev = granted;
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [31:0] r;
    bit          seen_we;
    bus_if.i_S_CE    = 1'b0;
    bus_if.i_S_REQ   = 1'b0;
    bus_if.i_S_WE    = 1'b0;
    bus_if.i_S_ADDR  = '0;
    bus_if.i_S_WDATA = '0;
    m_src = '0; m_dst = '0; m_len = '0; m_irq_en = 1'b0; m_done = 1'b0;

    repeat (3) @(negedge clk);
    checkOutput("rst_m_req", 32'(bus_if.o_M_REQ), 32'd0);
    checkOutput("rst_s_gnt", 32'(bus_if.o_S_GNT), 32'd0);
    checkOutput("rst_irq",   32'(bus_if.o_IRQ),   32'd0);
    checkOutput("rst_hb",    32'(bus_if.o_M_HB),  32'd2);
    rst = 1'b0;
    @(negedge clk);
    checkRegs(1'b0);

    $display("[TB] directed 3-word copy");
    setBusMode(0, 1'b1, 1'b0);
    startTransfer(32'h9000_0000, 32'h9000_0100, 3, 1'b0);
    finishTransfer(100);
    checkOutput("copy3_wr_count", 32'(wr_count), 32'd3);
    checkOutput("copy3_last_dst", last_wr_addr, 32'h9000_0108);
    checkOutput("copy3_last_src", rd_log[2], 32'h9000_0008);

    $display("[TB] zero-length start with interrupt");
    startTransfer(32'h1111_0000, 32'h2222_0000, 0, 1'b1);
    checkOutput("len0_irq_next_cycle", 32'(irq_after_gnt), 32'd0);
    checkOutput("len0_irq_two_cycles", 32'(bus_if.o_IRQ), 32'd1);
    m_done = 1'b1;
    busRead(REG_CTRL, r);
    checkOutput("len0_ctrl", r, 32'h0000_0006);
    applyStimulus(REG_CTRL, 32'h0000_0004);
    m_irq_en = 1'b0;
    m_done   = 1'b0;
    checkOutput("len0_irq_cleared", 32'(bus_if.o_IRQ), 32'd0);

    $display("[TB] slow grant copy");
    setBusMode(5, 1'b1, 1'b0);
    startTransfer(32'h7000_0040, 32'h7100_0000, 2, 1'b1);
    finishTransfer(200);

    $display("[TB] writes and START while busy");
    startTransfer(32'h5000_0000, 32'h6000_0000, 4, 1'b0);
    busRead(REG_CTRL, r);
    checkOutput("busy_ctrl", r, ctrl_exp(1'b1));
    applyStimulus(REG_SRC, 32'h1234_5678);
    applyStimulus(REG_LEN, 32'd7);
    applyStimulus(REG_CTRL, 32'h0000_0001);
    busRead(REG_SRC, r);
    checkOutput("busy_src_kept", r, 32'h5000_0000);
    busRead(REG_LEN, r);
    checkOutput("busy_len_kept", r, 32'd4);
    finishTransfer(300);
    checkOutput("busy_wr_count", 32'(wr_count), 32'd4);

    $display("[TB] source pointer wrap");
    setBusMode(1, 1'b0, 1'b1);
    startTransfer(32'hFFFF_FFFC, 32'h0000_1000, 2, 1'b0);
    finishTransfer(100);
    checkOutput("wrap_second_rd", rd_log[1], 32'h0000_0000);

    $display("[TB] randomized transfers");
    for (int t = 0; t < 10; t++) begin
      setBusMode(int'($urandom_range(0, 3)), 1'b0, 1'b1);
      startTransfer(32'h1000_0000 | ($urandom & 32'h0FFF_FFFC),
                    32'h2000_0000 | ($urandom & 32'h0FFF_FFFC),
                    int'($urandom_range(1, 6)), 1'($urandom_range(0, 1)));
      finishTransfer(300);
    end

    $display("[TB] reset during write phase");
    setBusMode(3, 1'b1, 1'b0);
    startTransfer(32'h3000_0000, 32'h4000_0000, 4, 1'b1);
    seen_we = 1'b0;
    for (int i = 0; i < 200 && !seen_we; i++) begin
      @(negedge clk);
      if (bus_if.o_M_WE) seen_we = 1'b1;
    end
    checkOutput("reached_write", 32'(seen_we), 32'd1);
    #1 rst = 1'b1;
    #1 checkOutput("async_rst_m_req", 32'(bus_if.o_M_REQ), 32'd0);
    exp_q.delete();
    m_src = '0; m_dst = '0; m_len = '0; m_irq_en = 1'b0; m_done = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    checkRegs(1'b0);
    checkOutput("post_rst_irq", 32'(bus_if.o_IRQ), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/dma_engine.md
DMA_ENGINE -- requirements
Module: dma_engine

Interface
REQ-001 Parameter LEN_W, default 16, width of the transfer word count.
REQ-002 i_CLK  input  1  single clock; all state changes on rising edge.
REQ-003 i_RST  input  1  asynchronous, active-high reset.
REQ-004 i_S_CE  input  1  responder chip enable from the bus CE decode.
REQ-005 i_S_REQ  input  1  responder request.
REQ-006 i_S_WE  input  1  responder write enable.
REQ-007 i_S_ADDR  input  4  responder register byte offset.
REQ-008 i_S_WDATA  input  32  responder write data.
REQ-009 o_S_RDATA  output  32  responder read data.
REQ-010 o_S_GNT  output  1  responder grant.
REQ-011 o_M_REQ  output  1  initiator request.
REQ-012 o_M_RE  output  1  initiator read strobe.
REQ-013 o_M_WE  output  1  initiator write strobe.
REQ-014 o_M_ADDR  output  32  initiator byte address.
REQ-015 o_M_WDATA  output  32  initiator write data.
REQ-016 o_M_HB  output  2  initiator access size, fixed 2'b10 (word).
REQ-017 i_M_GNT  input  1  initiator grant.
REQ-018 i_M_RDATA  input  32  initiator read data, valid in the i_M_GNT cycle.
REQ-019 o_IRQ  output  1  level interrupt, to a core MEI input.

Function
REQ-020 Registers: 0x0 SRC, 0x4 DST, 0x8 LEN (low LEN_W bits, word count), 0xC CTRL. CTRL write: bit0 START, bit1 IRQ_EN, bit2 DONE write-1-to-clear. CTRL read: bit0 BUSY, bit1 IRQ_EN, bit2 DONE, other bits 0.
REQ-021 Responder: i_S_CE&i_S_REQ in cycle N gives a one-cycle o_S_GNT pulse in N+1, o_S_RDATA valid in N+1; a write takes effect at the N edge; o_S_GNT low the cycle after any grant.
REQ-022 SRC/DST/LEN writes while BUSY are ignored but still granted.
REQ-023 FSM states: IDLE, RD, WR, FIN.
REQ-024 IDLE: START=1 with LEN≠0 loads SRC/DST/LEN into working pointers/count, sets BUSY, goes RD; START with LEN=0 goes FIN with no bus traffic.
REQ-025 RD: o_M_REQ=1, o_M_RE=1, o_M_ADDR=src pointer; on i_M_GNT latch i_M_RDATA, go WR.
REQ-026 WR: o_M_REQ=1, o_M_WE=1, o_M_ADDR=dst pointer, o_M_WDATA=latched word; on i_M_GNT both pointers +4 (modulo 2^32), count −1; go FIN if count was 1, else RD.
REQ-027 o_M_REQ deasserts for exactly one cycle after every i_M_GNT; address/data/strobes stable while o_M_REQ high.
REQ-028 i_M_GNT outside an active request is ignored.
REQ-029 FIN: set DONE, clear BUSY, go IDLE in one cycle.
REQ-030 o_IRQ = DONE & IRQ_EN; DONE stays set until cleared by a write; a clear coinciding with FIN leaves DONE set.
REQ-031 START while BUSY is ignored; an IRQ_EN write always takes effect.

Reset
REQ-032 i_RST forces IDLE; all registers, pointers, count and DONE to 0; o_M_REQ/RE/WE, o_S_GNT and o_IRQ to 0; o_M_HB to 2'b10.
REQ-033 Reset mid-transfer aborts immediately; no further bus request is issued.

Structure
REQ-034 Package dma_pkg holds register offsets, CTRL bit positions, FSM state encoding and HB encodings.
REQ-035 Single module, no sub-modules.

Verification
REQ-036 SRC=0x90000000, DST=0x90000100, LEN=3, START -> 3 RD/WR pairs; DST words equal SRC words; final pointers 0x9000000C/0x9000010C; DONE=1.
REQ-037 LEN=0, START with IRQ_EN=1 -> no o_M_REQ; o_IRQ=1 two cycles after the write; write 0x4 to CTRL -> o_IRQ=0.
REQ-038 i_M_GNT delayed 5 cycles on each request -> o_M_ADDR/WDATA/strobes stable throughout; transfer completes correctly.
REQ-039 Write SRC=0x12345678 while BUSY -> SRC readback unchanged; second START ignored; LEN count unchanged.
REQ-040 SRC=0xFFFFFFFC, LEN=2 -> second read address 0x00000000.
REQ-041 i_RST asserted during WR -> o_M_REQ=0 asynchronously; all registers read 0 after release.
